// File: rtl/mem_rd_rsp_mon_if.sv
// Read-port monitor bundle: memory-side inputs, response handshake,
// sticky error flags and counters. master = environment, slave = monitor.
interface mem_rd_rsp_mon_if #(
  parameter int AW = 13,
  parameter int DW = 32
);
  logic          read;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          read_vld;
  logic          read_serr;
  logic          read_derr;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          rsp_serr;
  logic          rsp_derr;
  logic          err_clr;
  logic          err_vld_miss;
  logic          err_vld_spur;
  logic          err_ovfl;
  logic          err_ecc;
  logic [3:0]    pend_cnt;
  logic [31:0]   rsp_cnt;

  modport master (
    output read, addr, dout,
    output read_vld, read_serr, read_derr,
    output rsp_rdy, err_clr,
    input  rsp_vld, rsp_addr, rsp_data,
    input  rsp_serr, rsp_derr,
    input  err_vld_miss, err_vld_spur,
    input  err_ovfl, err_ecc,
    input  pend_cnt, rsp_cnt
  );

  modport slave (
    input  read, addr, dout,
    input  read_vld, read_serr, read_derr,
    input  rsp_rdy, err_clr,
    output rsp_vld, rsp_addr, rsp_data,
    output rsp_serr, rsp_derr,
    output err_vld_miss, err_vld_spur,
    output err_ovfl, err_ecc,
    output pend_cnt, rsp_cnt
  );
endinterface

// File: rtl/mem_rd_rsp_mon.sv
// Memory read-response monitor: tracks reads through a LATENCY pipe,
// captures returns into a FIFO. Ports: clk, rst (async low), bus (slave).
module mem_rd_rsp_mon #(
  parameter int AW           = 13,
  parameter int DW           = 32,
  parameter int LATENCY      = 2,
  parameter int DEPTH        = 8,
  parameter bit CHK_READ_VLD = 1'b0,
  parameter bit CHK_READ_ERR = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  mem_rd_rsp_mon_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          serr;
    logic          derr;
  } ent_t;

  logic [LATENCY-1:0] r_pvld;
  logic [AW-1:0]      r_paddr [LATENCY];
  ent_t               r_mem   [DEPTH];
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;
  logic               r_miss;
  logic               r_spur;
  logic               r_ovfl;
  logic               r_ecc;
  logic [31:0]        r_rsp_cnt;

  logic w_exp;
  logic w_push;
  logic w_full;
  logic w_vld;
  logic w_pop;
  logic w_wr;
  logic w_drop;
  logic w_miss;
  logic w_spur;
  logic w_ecc;
  ent_t w_ent;
  ent_t w_head;

  // Last stage lines up with the cycle dout returns.
  assign w_exp  = r_pvld[LATENCY-1];
  assign w_push = w_exp & (~CHK_READ_VLD | bus.read_vld);
  assign w_miss = CHK_READ_VLD & w_exp & ~bus.read_vld;
  assign w_spur = CHK_READ_VLD & ~w_exp & bus.read_vld;
  assign w_ecc  = CHK_READ_ERR & w_push
                & (bus.read_serr | bus.read_derr);

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_vld  = (r_cnt != '0);
  assign w_pop  = w_vld & bus.rsp_rdy;
  // When full, the written slot is the head being popped this cycle.
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  assign w_ent.addr = r_paddr[LATENCY-1];
  assign w_ent.data = bus.dout;
  assign w_ent.serr = bus.read_serr;
  assign w_ent.derr = bus.read_derr;

  // Unwritten slots may be X; keep outputs zero when empty.
  assign w_head = w_vld ? r_mem[r_rp] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pvld <= '0;
      for (int i = 0; i < LATENCY; i++)
        r_paddr[i] <= '0;
    end else begin
      r_pvld[0]  <= bus.read;
      r_paddr[0] <= bus.addr;
      for (int i = 1; i < LATENCY; i++) begin
        r_pvld[i]  <= r_pvld[i-1];
        r_paddr[i] <= r_paddr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wp] <= w_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_rsp_cnt <= '0;
    end else begin
      if (w_wr)
        r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp      <= r_rp + 1'b1;
        r_rsp_cnt <= r_rsp_cnt + 32'd1;
      end
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
    end
  end

  // New errors win over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss <= 1'b0;
      r_spur <= 1'b0;
      r_ovfl <= 1'b0;
      r_ecc  <= 1'b0;
    end else begin
      r_miss <= (r_miss & ~bus.err_clr) | w_miss;
      r_spur <= (r_spur & ~bus.err_clr) | w_spur;
      r_ovfl <= (r_ovfl & ~bus.err_clr) | w_drop;
      r_ecc  <= (r_ecc  & ~bus.err_clr) | w_ecc;
    end
  end

  assign bus.rsp_vld      = w_vld;
  assign bus.rsp_addr     = w_head.addr;
  assign bus.rsp_data     = w_head.data;
  assign bus.rsp_serr     = w_head.serr;
  assign bus.rsp_derr     = w_head.derr;
  assign bus.err_vld_miss = r_miss;
  assign bus.err_vld_spur = r_spur;
  assign bus.err_ovfl     = r_ovfl;
  assign bus.err_ecc      = r_ecc;
  assign bus.pend_cnt     = 4'($countones(r_pvld));
  assign bus.rsp_cnt      = r_rsp_cnt;

endmodule

// File: tb/tb_mem_rd_rsp_mon.sv
// Directed bench for mem_rd_rsp_mon: u0 ignores read_vld/ecc,
// u1 checks both. Shared stimulus drives the two instances.
module tb_mem_rd_rsp_mon;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read = 1'b0;
  logic [12:0] addr = '0;
  logic        auto = 1'b0;
  logic        man_vld = 1'b0;
  logic [31:0] man_dout = '0;
  logic        serr = 1'b0;
  logic        derr = 1'b0;
  logic        rsp_rdy = 1'b0;
  logic        err_clr = 1'b0;
  logic        d1 = 1'b0;
  logic        d2 = 1'b0;
  logic [12:0] a1 = '0;
  logic [12:0] a2 = '0;
  logic        vld_in;
  logic [31:0] dout_in;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Reference 2-cycle delay of the read stream for auto returns.
  always @(posedge clk) begin
    d1 <= read;
    d2 <= d1;
    a1 <= addr;
    a2 <= a1;
  end

  assign vld_in  = auto ? d2 : man_vld;
  assign dout_in = auto ? {16'hC0DE, 3'b000, a2} : man_dout;

  mem_rd_rsp_mon_if #(.AW(13), .DW(32)) if0 ();
  mem_rd_rsp_mon_if #(.AW(13), .DW(32)) if1 ();

  assign if0.read      = read;
  assign if0.addr      = addr;
  assign if0.dout      = dout_in;
  assign if0.read_vld  = vld_in;
  assign if0.read_serr = serr;
  assign if0.read_derr = derr;
  assign if0.rsp_rdy   = rsp_rdy;
  assign if0.err_clr   = err_clr;
  assign if1.read      = read;
  assign if1.addr      = addr;
  assign if1.dout      = dout_in;
  assign if1.read_vld  = vld_in;
  assign if1.read_serr = serr;
  assign if1.read_derr = derr;
  assign if1.rsp_rdy   = rsp_rdy;
  assign if1.err_clr   = err_clr;

  mem_rd_rsp_mon #(
    .AW(13), .DW(32), .LATENCY(2), .DEPTH(8),
    .CHK_READ_VLD(1'b0), .CHK_READ_ERR(1'b0)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  mem_rd_rsp_mon #(
    .AW(13), .DW(32), .LATENCY(2), .DEPTH(8),
    .CHK_READ_VLD(1'b1), .CHK_READ_ERR(1'b1)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_vld0", if0.rsp_vld, 0);
    chk("rst_addr0", if0.rsp_addr, 0);
    chk("rst_data0", if0.rsp_data, 0);
    chk("rst_cnt0", if0.rsp_cnt, 0);
    chk("rst_pend0", if0.pend_cnt, 0);
    chk("rst_flags1", {if1.err_vld_miss, if1.err_vld_spur,
                       if1.err_ovfl, if1.err_ecc}, 0);
    rst = 1'b1;
    tick();

    // Single read, latency 2
    auto = 1'b0;
    rsp_rdy = 1'b1;
    read = 1'b1;
    addr = 13'h005;
    tick();
    read = 1'b0;
    chk("pend1", if0.pend_cnt, 1);
    tick();
    man_vld = 1'b1;
    man_dout = 32'hDEADBEEF;
    tick();
    man_vld = 1'b0;
    man_dout = '0;
    chk("t1_vld", if0.rsp_vld, 1);
    chk("t1_addr", if0.rsp_addr, 13'h005);
    chk("t1_data", if0.rsp_data, 32'hDEADBEEF);
    chk("t1_vld_u1", if1.rsp_vld, 1);
    tick();
    chk("t1_cnt", if0.rsp_cnt, 1);
    chk("t1_empty", if0.rsp_vld, 0);
    chk("t1_noerr1", {if1.err_vld_miss, if1.err_vld_spur}, 0);

    // Overflow: 10 reads into depth 8 with no drain
    auto = 1'b1;
    rsp_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      read = 1'b1;
      addr = 13'h010 + 13'(i);
      tick();
    end
    read = 1'b0;
    tick();
    tick();
    chk("ov_vld", if0.rsp_vld, 1);
    chk("ov_flag", if0.err_ovfl, 1);
    chk("ov_flag1", if1.err_ovfl, 1);
    chk("ov_pend", if0.pend_cnt, 0);
    rsp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ov_dr_addr", if0.rsp_addr, 13'h010 + 13'(i));
      chk("ov_dr_data", if0.rsp_data,
          {16'hC0DE, 3'b000, 13'h010 + 13'(i)});
      chk("ov_dr_addr1", if1.rsp_addr, 13'h010 + 13'(i));
      tick();
    end
    chk("ov_drained", if0.rsp_vld, 0);
    chk("ov_cnt", if0.rsp_cnt, 9);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ov_clr", if0.err_ovfl, 0);

    // Full FIFO with concurrent push and pop
    rsp_rdy = 1'b0;
    for (int c = 0; c < 26; c++) begin
      read = (c < 16);
      addr = 13'h020 + 13'(c);
      rsp_rdy = (c >= 10);
      if (c >= 10) begin
        chk("fp_vld", if0.rsp_vld, 1);
        chk("fp_addr", if0.rsp_addr, 13'h020 + 13'(c - 10));
        chk("fp_addr1", if1.rsp_addr, 13'h020 + 13'(c - 10));
      end
      tick();
    end
    read = 1'b0;
    chk("fp_empty", if0.rsp_vld, 0);
    chk("fp_noovfl", if0.err_ovfl, 0);
    chk("fp_noovfl1", if1.err_ovfl, 0);
    chk("fp_cnt", if0.rsp_cnt, 25);

    // read_vld checking: miss, spurious, clear
    auto = 1'b0;
    rsp_rdy = 1'b1;
    read = 1'b1;
    addr = 13'h030;
    tick();
    read = 1'b0;
    tick();
    man_vld = 1'b0;
    tick();
    chk("miss1", if1.err_vld_miss, 1);
    chk("miss_nopush1", if1.rsp_vld, 0);
    chk("miss_push0", if0.rsp_vld, 1);
    chk("miss_addr0", if0.rsp_addr, 13'h030);
    man_vld = 1'b1;
    tick();
    man_vld = 1'b0;
    chk("spur1", if1.err_vld_spur, 1);
    chk("spur_miss_sticky", if1.err_vld_miss, 1);
    chk("spur_nopush1", if1.rsp_vld, 0);
    chk("spur_ign0", if0.err_vld_spur, 0);
    chk("miss_ign0", if0.err_vld_miss, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_miss", if1.err_vld_miss, 0);
    chk("clr_spur", if1.err_vld_spur, 0);
    err_clr = 1'b1;
    man_vld = 1'b1;
    tick();
    err_clr = 1'b0;
    man_vld = 1'b0;
    chk("clr_vs_set", if1.err_vld_spur, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_again", if1.err_vld_spur, 0);
    chk("cnt_u0", if0.rsp_cnt, 26);
    chk("cnt_u1", if1.rsp_cnt, 25);

    // ECC pass-through and flag
    read = 1'b1;
    addr = 13'h040;
    tick();
    read = 1'b0;
    tick();
    man_vld = 1'b1;
    man_dout = 32'h12345678;
    derr = 1'b1;
    tick();
    man_vld = 1'b0;
    man_dout = '0;
    derr = 1'b0;
    chk("ecc_vld0", if0.rsp_vld, 1);
    chk("ecc_derr0", if0.rsp_derr, 1);
    chk("ecc_serr0", if0.rsp_serr, 0);
    chk("ecc_data0", if0.rsp_data, 32'h12345678);
    chk("ecc_flag0", if0.err_ecc, 0);
    chk("ecc_derr1", if1.rsp_derr, 1);
    chk("ecc_flag1", if1.err_ecc, 1);
    tick();

    // Reset with 3 buffered and 2 in flight
    auto = 1'b1;
    rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      read = 1'b1;
      addr = 13'h050 + 13'(i);
      tick();
    end
    read = 1'b0;
    chk("pre_pend", if0.pend_cnt, 2);
    chk("pre_vld", if0.rsp_vld, 1);
    chk("pre_head", if0.rsp_addr, 13'h050);
    auto = 1'b0;
    rst = 1'b0;
    #1;
    chk("ar_vld", if0.rsp_vld, 0);
    chk("ar_pend", if0.pend_cnt, 0);
    chk("ar_cnt", if0.rsp_cnt, 0);
    chk("ar_addr", if0.rsp_addr, 0);
    chk("ar_ecc1", if1.err_ecc, 0);
    tick();
    chk("ar_hold_vld", if1.rsp_vld, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("post_spur0", if1.err_vld_spur, 0);
    man_vld = 1'b1;
    man_dout = 32'hBAD0BAD0;
    tick();
    man_vld = 1'b0;
    man_dout = '0;
    chk("post_spur1", if1.err_vld_spur, 1);
    chk("post_nostale0", if0.rsp_vld, 0);
    chk("post_nostale1", if1.rsp_vld, 0);
    tick();
    tick();
    chk("post_still0", if0.rsp_vld, 0);
    chk("post_cnt0", if0.rsp_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
